niu_tx_arbiter: RTL and testbench
=================================

Name: niu_tx_arbiter

Overview:
- Shares the single 10GBASE-R MAC transmit AXI-Stream (64-bit, clk156 domain) between two upstream packet sources.
- Arbitration is packet-granular round-robin; a grant is held until tlast.
- A source that stalls mid-packet is aborted with an errored terminating beat, so the MAC is never wedged.
- Sits between the packet engines and the NIU tx_axis port; gated by the NIU reset-done/link indication.

Parameters:
- DATA_WIDTH, 64, tdata width.
- KEEP_WIDTH, 8, tkeep width (DATA_WIDTH/8).
- STALL_TIMEOUT, 1024, consecutive cycles a granted source may hold tvalid low mid-packet before abort (≥2).
- CNT_WIDTH, 32, width of statistics counters.

Ports:
- clk156 in 1 156.25 MHz clock; all logic on its rising edge.
- reset in 1 synchronous, active-high reset.
- link_up in 1 new grants allowed only when 1 (driven by network_reset_done).
- s0_axis_tdata/tkeep/tvalid/tlast in DATA_WIDTH/KEEP_WIDTH/1/1 source 0 stream.
- s0_axis_tready out 1 source 0 ready.
- s1_axis_tdata/tkeep/tvalid/tlast in DATA_WIDTH/KEEP_WIDTH/1/1 source 1 stream.
- s1_axis_tready out 1 source 1 ready.
- m_axis_tdata/tkeep out DATA_WIDTH/KEEP_WIDTH to MAC.
- m_axis_tvalid/tlast/tuser out 1 to MAC; tuser=1 marks an aborted frame.
- m_axis_tready in 1 MAC ready.
- grant out 2 one-hot current owner, 00 when none.
- pkt_cnt0, pkt_cnt1 out CNT_WIDTH completed packets per source (wrapping).
- abort_cnt out CNT_WIDTH aborts, both sources (wrapping).

Behaviour:
- States: IDLE, XFER, ABORT, DRAIN. Registers: state, sel (0/1), last (last served source), stall_cnt, counters.
- Reset values: state=IDLE, last=1 (source 0 wins first tie), sel=0, stall_cnt=0, all counters 0. Outputs during reset/IDLE: m_axis_tvalid=0, tlast=0, tuser=0, tdata=0, tkeep=0, s*_tready=0, grant=00.
- IDLE → XFER:
  - Condition: link_up=1 and any s*_tvalid=1. Only one requesting → sel=that source. Both requesting → sel=~last.
  - The grant registers this cycle; first beat can pass the following cycle. link_up=0 blocks new grants only.
- XFER, combinational pass-through, zero latency:
  - m_axis_{tdata,tkeep,tvalid,tlast} = selected source's signals; m_axis_tuser=0.
  - s[sel]_tready = m_axis_tready; other source's tready=0. grant = one-hot(sel).
  - Beat accepted when m_axis_tvalid & m_axis_tready. Accepted beat with tlast → IDLE; last=sel; pkt_cnt[sel]++.
  - A link_up drop mid-packet does not interrupt the packet.
- Stall timeout:
  - stall_cnt clears on entry to XFER and on any XFER cycle with s[sel]_tvalid=1; increments otherwise.
  - MAC backpressure (tready=0 with tvalid=1) never counts.
  - Cycle with s[sel]_tvalid=0 and stall_cnt==STALL_TIMEOUT-1 → ABORT, i.e. abort after STALL_TIMEOUT consecutive idle cycles.
- ABORT:
  - Drives m_axis_tvalid=1, tlast=1, tuser=1, tkeep=01h, tdata=0; all s*_tready=0; grant held.
  - On m_axis_tready=1 → DRAIN; abort_cnt++; last=sel.
- DRAIN:
  - m_axis_tvalid=0; s[sel]_tready=1; beats from sel are discarded.
  - Accepted tlast from sel → IDLE. No timeout in DRAIN; pkt_cnt not incremented.
- Zero-length packets do not exist: a single beat with tlast is a complete packet.
- Counters wrap at 2^CNT_WIDTH.
- Reset asserted in any state → IDLE next edge. An in-flight packet is truncated with no tlast; this is acceptable because the MAC is reset concurrently.

Test Plan:
- Single source: s0 sends 4-beat packet, tkeep FF/FF/FF/0F, m_tready=1. Required: IDLE→grant=01 next cycle; 4 beats appear unmodified and back-to-back; pkt_cnt0=1; grant=00 after tlast.
- Contention: both sources continuously offer 3-beat packets. Required: grant order after reset is 0,1,0,1; pkt_cnt0=pkt_cnt1=2 after 4 packets; no interleaving of beats within a packet.
- Backpressure: s1 4-beat packet, m_tready toggles 1,0,0,1… for 2000 cycles with s1_tvalid held high. Required: no abort; s1_tready mirrors m_tready; abort_cnt=0.
- Stall abort (STALL_TIMEOUT=16): s0 sends 2 beats, drops tvalid for 16 cycles. Required: errored beat tlast=1, tuser=1, tkeep=01h; abort_cnt=1. Then s0 sends 3 more beats ending tlast: all consumed, none reach MAC, pkt_cnt0 unchanged. Subsequent s1 packet is granted normally.
- Stall boundary: s0 idle mid-packet for exactly 15 cycles, then resumes. Required: no abort; packet completes; pkt_cnt0++.
- Link/reset: link_up=0 with s0_tvalid=1 → grant stays 00 until link_up=1. reset pulsed mid-XFER → next cycle all outputs at reset values and counters 0.

Source files
------------

// File: rtl/niu_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : niu_tx_arbiter
// Description : Packet-granular round-robin arbiter that shares the 10GBASE-R
//               MAC transmit AXI-Stream between two packet sources. A source
//               that stalls mid-packet is cut off with an errored terminating
//               beat and its remaining beats are drained and discarded.
// Revision    : 1.0 - initial release
// ============================================================================
module niu_tx_arbiter #(
    parameter int DATA_WIDTH    = 64,
    parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
    parameter int STALL_TIMEOUT = 1024,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                  clk156,
    input  logic                  reset,
    input  logic                  link_up,

    input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s0_axis_tkeep,
    input  logic                  s0_axis_tvalid,
    input  logic                  s0_axis_tlast,
    output logic                  s0_axis_tready,

    input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s1_axis_tkeep,
    input  logic                  s1_axis_tvalid,
    input  logic                  s1_axis_tlast,
    output logic                  s1_axis_tready,

    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    input  logic                  m_axis_tready,

    output logic [1:0]            grant,
    output logic [CNT_WIDTH-1:0]  pkt_cnt0,
    output logic [CNT_WIDTH-1:0]  pkt_cnt1,
    output logic [CNT_WIDTH-1:0]  abort_cnt
);

    // Stall counter only has to reach STALL_TIMEOUT-1 before the abort fires.
    localparam int                c_stall_w    = $clog2(STALL_TIMEOUT);
    localparam logic [c_stall_w-1:0] c_stall_last = c_stall_w'(STALL_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_ABORT = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t                 r_state;
    logic                   r_sel;
    logic                   r_last;
    logic [c_stall_w-1:0]   r_stall_cnt;
    logic [1:0]             r_grant;
    logic [CNT_WIDTH-1:0]   r_pkt_cnt0;
    logic [CNT_WIDTH-1:0]   r_pkt_cnt1;
    logic [CNT_WIDTH-1:0]   r_abort_cnt;

    logic                   w_sel_tvalid;
    logic                   w_sel_tlast;
    logic                   w_any_req;
    logic                   w_pick;

    assign w_sel_tvalid = r_sel ? s1_axis_tvalid : s0_axis_tvalid;
    assign w_sel_tlast  = r_sel ? s1_axis_tlast  : s0_axis_tlast;
    assign w_any_req    = s0_axis_tvalid | s1_axis_tvalid;
    // Lone requester wins outright; on a tie the source not served last wins.
    assign w_pick       = (s0_axis_tvalid & s1_axis_tvalid) ? ~r_last : s1_axis_tvalid;

    assign grant     = r_grant;
    assign pkt_cnt0  = r_pkt_cnt0;
    assign pkt_cnt1  = r_pkt_cnt1;
    assign abort_cnt = r_abort_cnt;

    // Output steering: zero-latency pass-through in XFER, error beat in ABORT.
    always_comb begin
        m_axis_tdata   = '0;
        m_axis_tkeep   = '0;
        m_axis_tvalid  = 1'b0;
        m_axis_tlast   = 1'b0;
        m_axis_tuser   = 1'b0;
        s0_axis_tready = 1'b0;
        s1_axis_tready = 1'b0;
        case (r_state)
            ST_XFER: begin
                m_axis_tdata   = r_sel ? s1_axis_tdata : s0_axis_tdata;
                m_axis_tkeep   = r_sel ? s1_axis_tkeep : s0_axis_tkeep;
                m_axis_tvalid  = w_sel_tvalid;
                m_axis_tlast   = w_sel_tlast;
                s0_axis_tready = ~r_sel & m_axis_tready;
                s1_axis_tready =  r_sel & m_axis_tready;
            end
            ST_ABORT: begin
                m_axis_tvalid  = 1'b1;
                m_axis_tlast   = 1'b1;
                m_axis_tuser   = 1'b1;
                m_axis_tkeep   = KEEP_WIDTH'(1);
            end
            ST_DRAIN: begin
                s0_axis_tready = ~r_sel;
                s1_axis_tready =  r_sel;
            end
            default: begin
            end
        endcase
    end

    // Arbitration FSM, stall watchdog, registered grant and statistics.
    always_ff @(posedge clk156) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_sel       <= 1'b0;
            r_last      <= 1'b1;
            r_stall_cnt <= '0;
            r_grant     <= 2'b00;
            r_pkt_cnt0  <= '0;
            r_pkt_cnt1  <= '0;
            r_abort_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (link_up && w_any_req) begin
                        r_state     <= ST_XFER;
                        r_sel       <= w_pick;
                        r_grant     <= w_pick ? 2'b10 : 2'b01;
                        r_stall_cnt <= '0;
                    end
                end
                ST_XFER: begin
                    if (w_sel_tvalid && m_axis_tready && w_sel_tlast) begin
                        r_state <= ST_IDLE;
                        r_last  <= r_sel;
                        r_grant <= 2'b00;
                        if (r_sel) begin
                            r_pkt_cnt1 <= r_pkt_cnt1 + CNT_WIDTH'(1);
                        end else begin
                            r_pkt_cnt0 <= r_pkt_cnt0 + CNT_WIDTH'(1);
                        end
                    end else if (w_sel_tvalid) begin
                        // Source is offering data; MAC backpressure is not a stall.
                        r_stall_cnt <= '0;
                    end else if (r_stall_cnt == c_stall_last) begin
                        r_state <= ST_ABORT;
                    end else begin
                        r_stall_cnt <= r_stall_cnt + c_stall_w'(1);
                    end
                end
                ST_ABORT: begin
                    if (m_axis_tready) begin
                        r_state     <= ST_DRAIN;
                        r_last      <= r_sel;
                        r_abort_cnt <= r_abort_cnt + CNT_WIDTH'(1);
                    end
                end
                ST_DRAIN: begin
                    // Tready is forced high here, so tvalid alone means accepted.
                    if (w_sel_tvalid && w_sel_tlast) begin
                        r_state <= ST_IDLE;
                        r_grant <= 2'b00;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_niu_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_niu_tx_arbiter
// Description : Self-checking bench for niu_tx_arbiter: directed scenarios
//               plus randomized traffic compared every cycle against a
//               behavioural model of the arbitration rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_niu_tx_arbiter;

    localparam int TO = 16;

    logic        clk156 = 1'b0;
    logic        reset  = 1'b1;
    logic        link_up = 1'b0;
    logic [63:0] s_tdata  [2] = '{64'd0, 64'd0};
    logic [7:0]  s_tkeep  [2] = '{8'd0, 8'd0};
    logic        s_tvalid [2] = '{1'b0, 1'b0};
    logic        s_tlast  [2] = '{1'b0, 1'b0};
    logic        s0_tready, s1_tready;
    logic        m_tready = 1'b1;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic        m_tvalid, m_tlast, m_tuser;
    logic [1:0]  grant;
    logic [31:0] pkt_cnt0, pkt_cnt1, abort_cnt;

    always #5 clk156 = ~clk156;

    niu_tx_arbiter #(
        .DATA_WIDTH(64), .KEEP_WIDTH(8), .STALL_TIMEOUT(TO), .CNT_WIDTH(32)
    ) dut (
        .clk156(clk156), .reset(reset), .link_up(link_up),
        .s0_axis_tdata(s_tdata[0]), .s0_axis_tkeep(s_tkeep[0]),
        .s0_axis_tvalid(s_tvalid[0]), .s0_axis_tlast(s_tlast[0]),
        .s0_axis_tready(s0_tready),
        .s1_axis_tdata(s_tdata[1]), .s1_axis_tkeep(s_tkeep[1]),
        .s1_axis_tvalid(s_tvalid[1]), .s1_axis_tlast(s_tlast[1]),
        .s1_axis_tready(s1_tready),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
        .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser), .m_axis_tready(m_tready),
        .grant(grant), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .abort_cnt(abort_cnt)
    );

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got 0x%0h, want 0x%0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 nobody owns the MAC, 1 owner streaming, 2 error beat pending,
    // 3 owner's leftover beats being swallowed.
    int          md_phase = 0;
    int          md_owner = 0;
    int          md_last  = 1;
    int          md_quiet = 0;
    logic [31:0] md_pc [2] = '{32'd0, 32'd0};
    logic [31:0] md_ac = 32'd0;

    bit          acc [2] = '{1'b0, 1'b0};
    int          mac_beats = 0;
    int          err_beats = 0;
    logic [7:0]  err_keep = 8'd0;
    logic [1:0]  prev_grant = 2'b00;
    logic [1:0]  grant_log [$];

    logic        e_v, e_l, e_u, e_r0, e_r1, e_full;
    logic [63:0] e_d;
    logic [7:0]  e_k;
    logic [1:0]  e_g;

    // Single compare process: expectations from model state and current inputs.
    always @(negedge clk156) begin
        int o;
        o = md_owner;
        e_v = 0; e_l = 0; e_u = 0; e_d = '0; e_k = '0; e_r0 = 0; e_r1 = 0; e_full = 1;
        e_g = (md_phase == 0) ? 2'b00 : ((o == 1) ? 2'b10 : 2'b01);
        case (md_phase)
            1: begin
                e_v = s_tvalid[o]; e_l = s_tlast[o]; e_d = s_tdata[o]; e_k = s_tkeep[o];
                e_r0 = (o == 0) && m_tready; e_r1 = (o == 1) && m_tready;
            end
            2: begin
                e_v = 1; e_l = 1; e_u = 1; e_k = 8'h01;
            end
            3: begin
                e_r0 = (o == 0); e_r1 = (o == 1); e_full = 0;
            end
            default: ;
        endcase
        if (chk_en) begin
            check("grant", grant, e_g);
            check("m_tvalid", m_tvalid, e_v);
            check("s0_tready", s0_tready, e_r0);
            check("s1_tready", s1_tready, e_r1);
            check("pkt_cnt0", pkt_cnt0, md_pc[0]);
            check("pkt_cnt1", pkt_cnt1, md_pc[1]);
            check("abort_cnt", abort_cnt, md_ac);
            if (e_full) begin
                check("m_tlast", m_tlast, e_l);
                check("m_tuser", m_tuser, e_u);
                check("m_tdata", m_tdata, e_d);
                check("m_tkeep", m_tkeep, e_k);
            end
        end
        // handshake bookkeeping used by the stimulus
        acc[0] = s_tvalid[0] & s0_tready;
        acc[1] = s_tvalid[1] & s1_tready;
        if (m_tvalid === 1'b1 && m_tready) begin
            mac_beats++;
            if (m_tuser === 1'b1) begin err_beats++; err_keep = m_tkeep; end
        end
        if (grant != 2'b00 && prev_grant == 2'b00) grant_log.push_back(grant);
        prev_grant = grant;
        // model advance for the coming edge
        if (reset) begin
            md_phase = 0; md_owner = 0; md_last = 1; md_quiet = 0;
            md_pc[0] = 0; md_pc[1] = 0; md_ac = 0;
        end else begin
            case (md_phase)
                0: if (link_up && (s_tvalid[0] || s_tvalid[1])) begin
                    md_owner = (s_tvalid[0] && s_tvalid[1]) ? 1 - md_last : (s_tvalid[0] ? 0 : 1);
                    md_phase = 1; md_quiet = 0;
                end
                1: if (s_tvalid[o] && m_tready && s_tlast[o]) begin
                    md_pc[o] = md_pc[o] + 1; md_last = o; md_phase = 0;
                end else if (s_tvalid[o]) begin
                    md_quiet = 0;
                end else begin
                    md_quiet++;
                    if (md_quiet == TO) md_phase = 2;
                end
                2: if (m_tready) begin
                    md_ac = md_ac + 1; md_last = o; md_phase = 3;
                end
                3: if (s_tvalid[o] && s_tlast[o]) md_phase = 0;
                default: ;
            endcase
        end
    end

    // ---------------- stimulus helpers ----------------
    bit eng_en [2] = '{1'b0, 1'b0};
    int eng_fix [2] = '{0, 0};
    int beat [2] = '{0, 0};
    int plen [2] = '{1, 1};
    int nap [2] = '{0, 0};
    int pv = 100;
    bit nap_en = 0, link_rand = 0, rst_rand = 0;
    int tr_mode = 1;
    int bp_cyc = 0;

    task automatic tick();
        @(posedge clk156); #1;
    endtask

    task automatic clear_src();
        for (int s = 0; s < 2; s++) begin
            s_tvalid[s] = 0; s_tlast[s] = 0; s_tdata[s] = '0; s_tkeep[s] = '0;
        end
    endtask

    task automatic do_reset();
        eng_en[0] = 0; eng_en[1] = 0; link_rand = 0; rst_rand = 0; tr_mode = 1;
        m_tready = 1; clear_src();
        reset = 1; tick(); tick(); reset = 0;
    endtask

    task automatic present_beat(input int s);
        s_tvalid[s] = 1;
        s_tdata[s]  = {$urandom, $urandom};
        s_tlast[s]  = (beat[s] == plen[s] - 1);
        s_tkeep[s]  = s_tlast[s] ? 8'($urandom_range(1, 255)) : 8'hFF;
    endtask

    task automatic eng_init(input int fix0, input int fix1);
        eng_fix[0] = fix0; eng_fix[1] = fix1;
        for (int s = 0; s < 2; s++) begin
            beat[s] = 0; nap[s] = 0;
            plen[s] = (eng_fix[s] != 0) ? eng_fix[s] : $urandom_range(1, 6);
        end
    endtask

    // One cycle of random traffic; called just after a rising edge.
    task automatic engine_step();
        for (int s = 0; s < 2; s++) begin
            if (eng_en[s]) begin
                if (s_tvalid[s] && acc[s]) begin
                    if (s_tlast[s]) begin
                        beat[s] = 0;
                        plen[s] = (eng_fix[s] != 0) ? eng_fix[s] : $urandom_range(1, 6);
                    end else begin
                        beat[s]++;
                    end
                    s_tvalid[s] = 0;
                end
                if (!s_tvalid[s]) begin
                    if (nap[s] > 0) nap[s]--;
                    else if (nap_en && $urandom_range(0, 99) < 3) nap[s] = $urandom_range(8, 24);
                    else if ($urandom_range(0, 99) < pv) present_beat(s);
                end
            end
        end
        case (tr_mode)
            0: m_tready = ($urandom_range(0, 99) < 75);
            2: begin m_tready = (bp_cyc % 3 == 0); bp_cyc++; end
            default: m_tready = 1;
        endcase
        if (link_rand && $urandom_range(0, 199) == 0) link_up = ~link_up;
        if (rst_rand) reset = ($urandom_range(0, 4999) == 0);
    endtask

    // Directed packet: optional idle gap of gap_len cycles before beat gap_after.
    task automatic send(input int s, input int len, input int gap_after, input int gap_len,
                        input logic [7:0] lkeep, output int cyc);
        int w;
        cyc = 0;
        for (int b = 0; b < len; b++) begin
            if (b == gap_after && gap_len > 0) begin
                s_tvalid[s] = 0;
                repeat (gap_len) begin tick(); cyc++; end
            end
            s_tvalid[s] = 1; s_tdata[s] = {$urandom, $urandom};
            s_tlast[s]  = (b == len - 1);
            s_tkeep[s]  = (b == len - 1) ? lkeep : 8'hFF;
            w = 0;
            do begin tick(); cyc++; w++; end while (!acc[s] && w < 200);
            if (!acc[s]) begin
                tests++; fails++;
                $display("FAIL send_timeout src%0d beat%0d: got no handshake, want one within 200 cycles", s, b);
            end
        end
        s_tvalid[s] = 0; s_tlast[s] = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion, want finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc, mb0;
        tick();
        chk_en = 1;
        tick();
        reset = 0;

        // Single source, 4-beat packet: grant next cycle, beats back-to-back.
        do_reset(); link_up = 1;
        @(negedge clk156); check("t1_reset_grant", grant, 2'b00);
        check("t1_reset_pkt0", pkt_cnt0, 0);
        tick();
        mb0 = mac_beats;
        send(0, 4, -1, 0, 8'h0F, cyc);
        check("t1_cycles", cyc, 5);
        @(negedge clk156);
        check("t1_pkt0", pkt_cnt0, 1);
        check("t1_grant_after", grant, 2'b00);
        check("t1_mac_beats", mac_beats - mb0, 4);

        // Contention: both sources offering 3-beat packets continuously.
        do_reset(); link_up = 1; eng_init(3, 3); pv = 100; nap_en = 0;
        grant_log.delete();
        eng_en[0] = 1; eng_en[1] = 1;
        for (int w = 0; w < 300; w++) begin
            engine_step();
            @(negedge clk156);
            if (pkt_cnt0 + pkt_cnt1 >= 4) break;
            tick();
        end
        check("t2_pkt0", pkt_cnt0, 2);
        check("t2_pkt1", pkt_cnt1, 2);
        tick();
        eng_en[0] = 0; eng_en[1] = 0;
        check("t2_order0", grant_log[0], 2'b01);
        check("t2_order1", grant_log[1], 2'b10);
        check("t2_order2", grant_log[2], 2'b01);
        check("t2_order3", grant_log[3], 2'b10);

        // Backpressure: s1 streaming 4-beat packets under 1,0,0 tready pattern.
        do_reset(); link_up = 1; eng_init(4, 4); pv = 100; nap_en = 0;
        tr_mode = 2; bp_cyc = 0; eng_en[1] = 1;
        repeat (2000) begin engine_step(); tick(); end
        @(negedge clk156);
        check("t3_abort", abort_cnt, 0);
        check("t3_progress", pkt_cnt1 != 0, 1);

        // Stall abort: 2 beats, 16 idle cycles, then 3 beats that must be swallowed.
        do_reset(); link_up = 1;
        mb0 = mac_beats; err_beats = 0;
        send(0, 5, 2, 16, 8'hFF, cyc);
        @(negedge clk156);
        check("t4_abort", abort_cnt, 1);
        check("t4_pkt0", pkt_cnt0, 0);
        check("t4_mac_beats", mac_beats - mb0, 3);
        check("t4_err_beats", err_beats, 1);
        check("t4_err_keep", err_keep, 8'h01);
        tick();
        send(1, 2, -1, 0, 8'h3F, cyc);
        @(negedge clk156);
        check("t4_s1_pkt", pkt_cnt1, 1);

        // Stall boundary: 15 idle cycles mid-packet must not abort.
        do_reset(); link_up = 1;
        send(0, 4, 2, 15, 8'h07, cyc);
        @(negedge clk156);
        check("t5_abort", abort_cnt, 0);
        check("t5_pkt0", pkt_cnt0, 1);

        // Link gating and reset mid-transfer.
        do_reset(); link_up = 0;
        s_tvalid[0] = 1; s_tlast[0] = 1; s_tkeep[0] = 8'h01; s_tdata[0] = 64'h1234;
        repeat (6) tick();
        @(negedge clk156); check("t6_nolink_grant", grant, 2'b00);
        tick(); link_up = 1;
        @(negedge clk156); check("t6_link_grant0", grant, 2'b00);
        tick();
        @(negedge clk156); check("t6_link_grant1", grant, 2'b01);
        tick();
        @(negedge clk156); check("t6_pkt0", pkt_cnt0, 1);
        tick();
        s_tvalid[0] = 1; s_tlast[0] = 0; s_tkeep[0] = 8'hFF;
        repeat (3) tick();
        @(negedge clk156); check("t6_midxfer_grant", grant, 2'b01);
        tick(); reset = 1; tick();
        @(negedge clk156);
        check("t6_rst_grant", grant, 2'b00);
        check("t6_rst_tvalid", m_tvalid, 0);
        check("t6_rst_tready0", s0_tready, 0);
        check("t6_rst_tdata", m_tdata, 0);
        check("t6_rst_pkt0", pkt_cnt0, 0);
        tick(); reset = 0; clear_src();

        // Randomized traffic against the model.
        do_reset(); link_up = 1; eng_init(0, 0); pv = 60; nap_en = 1;
        tr_mode = 0; link_rand = 1; rst_rand = 1;
        eng_en[0] = 1; eng_en[1] = 1;
        repeat (20000) begin engine_step(); tick(); end
        eng_en[0] = 0; eng_en[1] = 0; rst_rand = 0; reset = 0;
        tick();
        @(negedge clk156);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
